// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with read-modify-write for partial stores
module dmem_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [XLEN-1:0]      wdata0,
  input  logic [XLEN-1:0]      wdata1,
  input  logic [3:0]           be0,
  input  logic [3:0]           be1,
  input  logic [ADDR_SIZE-1:0] pc0,
  input  logic [ADDR_SIZE-1:0] pc1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [XLEN-1:0]      rdata0,
  output logic [XLEN-1:0]      rdata1,
  output logic                 busy,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_a,
  output logic [XLEN-1:0]      mem_wd,
  output logic [ADDR_SIZE-1:0] mem_pc,
  input  logic [XLEN-1:0]      mem_rd
);

  typedef enum logic [1:0] {IDLE, ACC, WR, RSP} state_t;

  state_t                state, state_nx;
  logic                  we_q;
  logic [ADDR_SIZE-1:0]  addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [3:0]            be_q;
  logic [ADDR_SIZE-1:0]  pc_q;
  logic [XLEN-1:0]       rdata_q;
  logic [XLEN-1:0]       merge_q;
  logic [XLEN-1:0]       merged;
  logic                  owner_q;
  logic                  last_q;
  logic                  partial;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^addr_q[1:0];

  // Round-robin: on a tie, the port that did not win last time goes next.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (req0 && (!req1 || (FIXED_PRIO != 0) || last_q))
        gnt0 = 1'b1;
      else if (req1)
        gnt1 = 1'b1;
    end
  end

  assign partial = we_q && (be_q != 4'hF) && (be_q != 4'h0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (gnt0 || gnt1) state_nx = ACC;
      ACC:  state_nx = partial ? WR : RSP;
      WR:   state_nx = RSP;
      RSP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    merged = mem_rd;
    for (int i = 0; i < 4; i++)
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
  end

  assign mem_a  = {addr_q[ADDR_SIZE-1:2], 2'b00};
  assign mem_pc = pc_q;
  assign mem_we = ((state == ACC) && we_q && (be_q == 4'hF)) || (state == WR);
  assign mem_wd = (state == WR) ? merge_q : wdata_q;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      pc_q    <= '0;
      rdata_q <= '0;
      merge_q <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state <= state_nx;
      if (gnt0 || gnt1) begin
        we_q    <= gnt1 ? we1 : we0;
        addr_q  <= gnt1 ? addr1 : addr0;
        wdata_q <= gnt1 ? wdata1 : wdata0;
        be_q    <= gnt1 ? be1 : be0;
        pc_q    <= gnt1 ? pc1 : pc0;
        owner_q <= gnt1;
        last_q  <= gnt1;
      end
      if (state == ACC && !we_q) rdata_q <= mem_rd;
      if (state == ACC && partial) merge_q <= merged;
      // Response flops load on entry to RSP so rvalid/rdata line up with that state.
      rvalid0 <= (state_nx == RSP) && !owner_q;
      rvalid1 <= (state_nx == RSP) && owner_q;
      if (state_nx == RSP) begin
        if (!owner_q) rdata0 <= (state == ACC && !we_q) ? mem_rd : rdata_q;
        else          rdata1 <= (state == ACC && !we_q) ? mem_rd : rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter with a word memory model
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1, pc0, pc1;
  logic [3:0]  be0, be1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_we;
  logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_pc, mem_rd;

  logic        fp_req0, fp_req1;
  logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_busy, fp_mem_we;
  logic [31:0] fp_rdata0, fp_rdata1, fp_mem_a, fp_mem_wd, fp_mem_pc;
  logic [31:0] fp_zero32;
  logic [3:0]  fp_zero4;
  logic        fp_zero1;

  logic [31:0] mem [64];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

  dmem_arbiter #(.XLEN(32), .ADDR_SIZE(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1), .pc0(pc0), .pc1(pc1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_pc(mem_pc), .mem_rd(mem_rd)
  );

  dmem_arbiter #(.XLEN(32), .ADDR_SIZE(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rstn(rstn),
    .req0(fp_req0), .req1(fp_req1), .we0(fp_zero1), .we1(fp_zero1),
    .addr0(fp_zero32), .addr1(fp_zero32), .wdata0(fp_zero32), .wdata1(fp_zero32),
    .be0(fp_zero4), .be1(fp_zero4), .pc0(fp_zero32), .pc1(fp_zero32),
    .gnt0(fp_gnt0), .gnt1(fp_gnt1), .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1),
    .rdata0(fp_rdata0), .rdata1(fp_rdata1), .busy(fp_busy),
    .mem_we(fp_mem_we), .mem_a(fp_mem_a), .mem_wd(fp_mem_wd), .mem_pc(fp_mem_pc),
    .mem_rd(fp_zero32)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
    bit          chk_rd;
    logic [31:0] rd;
    int          lat;
    int          nwe;
    logic [31:0] wd;
  } vec_t;

  vec_t vt [10];

  task automatic drive(input bit p, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic [31:0] pc);
    if (!p) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; be0 = b; pc0 = pc; end
    else    begin req1 = r; we1 = w; addr1 = a; wdata1 = d; be1 = b; pc1 = pc; end
  endtask

  // Issues one transaction and returns what was observed from grant to response.
  task automatic run_txn(input vec_t v, output bit granted, output int lat, output int nwe,
                         output logic [31:0] wd, output logic [31:0] wa, output logic [31:0] wpc,
                         output logic [31:0] rd, output logic busy1);
    bit done;
    granted = 0; lat = -1; nwe = 0; wd = 'x; wa = 'x; wpc = 'x; rd = 'x; busy1 = 1'b0; done = 0;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata, v.be, v.pc);
    for (int i = 0; i < 20 && !granted; i++) begin
      @(negedge clk);
      if (v.port ? gnt1 : gnt0) granted = 1;
      @(posedge clk); #1;
    end
    drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    if (!granted) return;
    for (int c = 1; c <= 10 && !done; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = busy;
      if (mem_we) begin nwe++; wd = mem_wd; wa = mem_a; wpc = mem_pc; end
      if (v.port ? rvalid1 : rvalid0) begin
        lat = c; rd = v.port ? rdata1 : rdata0; done = 1;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          g;
    int          lat, nwe;
    logic [31:0] wd, wa, wpc, rd;
    logic        b1;
    int          gseq[$], gcyc[$], rcyc[$], rport[$];
    logic [31:0] rdat[$];
    int          fp_g0, fp_g1, both;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    fp_zero32 = 32'h0; fp_zero4 = 4'h0; fp_zero1 = 1'b0;
    fp_req0 = 1'b0; fp_req1 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);

    //        port we   addr   wdata         be     pc      chk  rd            lat nwe wd
    vt[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h100, 1'b0, 32'h0,        2, 1, 32'hDEADBEEF};
    vt[1] = '{1'b1, 1'b0, 32'h12, 32'h0,        4'hF, 32'h200, 1'b1, 32'hDEADBEEF, 2, 0, 32'h0};
    vt[2] = '{1'b0, 1'b1, 32'h11, 32'h0000AA00, 4'h2, 32'h104, 1'b0, 32'h0,        3, 1, 32'hDEADAAEF};
    vt[3] = '{1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 32'h204, 1'b1, 32'hDEADAAEF, 2, 0, 32'h0};
    vt[4] = '{1'b0, 1'b1, 32'h10, 32'h12345678, 4'h0, 32'h108, 1'b0, 32'h0,        2, 0, 32'h0};
    vt[5] = '{1'b0, 1'b0, 32'h13, 32'h0,        4'hF, 32'h10C, 1'b1, 32'hDEADAAEF, 2, 0, 32'h0};
    vt[6] = '{1'b1, 1'b1, 32'h20, 32'h11000022, 4'h9, 32'h208, 1'b0, 32'h0,        3, 1, 32'h11000022};
    vt[7] = '{1'b1, 1'b0, 32'h20, 32'h0,        4'hF, 32'h20C, 1'b1, 32'h11000022, 2, 0, 32'h0};
    vt[8] = '{1'b0, 1'b1, 32'h22, 32'h00AABB00, 4'h6, 32'h110, 1'b0, 32'h0,        3, 1, 32'h11AABB22};
    vt[9] = '{1'b0, 1'b0, 32'h20, 32'h0,        4'h0, 32'h114, 1'b1, 32'h11AABB22, 2, 0, 32'h0};

    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("reset gnt0",    {31'h0, gnt0},    32'h0);
    chk("reset rvalid0", {31'h0, rvalid0}, 32'h0);
    chk("reset rvalid1", {31'h0, rvalid1}, 32'h0);
    chk("reset rdata0",  rdata0,           32'h0);
    chk("reset rdata1",  rdata1,           32'h0);
    chk("reset busy",    {31'h0, busy},    32'h0);
    chk("reset mem_we",  {31'h0, mem_we},  32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_txn(vt[i], g, lat, nwe, wd, wa, wpc, rd, b1);
      chk($sformatf("v%0d granted", i), {31'h0, g}, 32'h1);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d mem_we count", i), 32'(nwe), 32'(vt[i].nwe));
      chk($sformatf("v%0d busy", i), {31'h0, b1}, 32'h1);
      if (vt[i].nwe != 0) begin
        chk($sformatf("v%0d mem_wd", i), wd, vt[i].wd);
        chk($sformatf("v%0d mem_a", i), wa, {vt[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d mem_pc", i), wpc, vt[i].pc);
      end
      if (vt[i].chk_rd) chk($sformatf("v%0d rdata", i), rd, vt[i].rd);
    end
    chk("rdata1 hold", rdata1, 32'h11000022);

    // Reset while a full store sits in ACC: write must be abandoned.
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h300);
    g = 0;
    for (int i = 0; i < 10 && !g; i++) begin
      @(negedge clk);
      if (gnt0) g = 1;
      @(posedge clk); #1;
    end
    chk("rst-mid granted", {31'h0, g}, 32'h1);
    chk("rst-mid mem_we before", {31'h0, mem_we}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("rst-mid mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst-mid busy", {31'h0, busy}, 32'h0);
    chk("rst-mid rvalid0", {31'h0, rvalid0}, 32'h0);
    chk("rst-mid rdata0", rdata0, 32'h0);
    chk("rst-mid rdata1", rdata1, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst-mid memory unchanged", mem[12], 32'h0);

    // Continuous contention on both instances.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h400);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 32'h500);
    fp_req0 = 1'b1; fp_req1 = 1'b1;
    fp_g0 = 0; fp_g1 = 0; both = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both++;
      if (gnt0 || gnt1) begin gseq.push_back(gnt1 ? 1 : 0); gcyc.push_back(c); end
      if (rvalid0 || rvalid1) begin
        rport.push_back(rvalid1 ? 1 : 0); rcyc.push_back(c);
        rdat.push_back(rvalid1 ? rdata1 : rdata0);
      end
      if (fp_gnt0) fp_g0++;
      if (fp_gnt1) fp_g1++;
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    fp_req0 = 1'b0; fp_req1 = 1'b0;

    chk("rr double grant", 32'(both), 32'h0);
    chk("rr grant count >= 4", {31'h0, gseq.size() >= 4}, 32'h1);
    chk("rr response count >= 4", {31'h0, rcyc.size() >= 4}, 32'h1);
    if (gseq.size() >= 4 && rcyc.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rr grant %0d port", k), 32'(gseq[k]), 32'(k % 2));
        chk($sformatf("rr resp %0d port", k), 32'(rport[k]), 32'(k % 2));
        chk($sformatf("rr resp %0d latency", k), 32'(rcyc[k] - gcyc[k]), 32'd2);
        if (k > 0) chk($sformatf("rr grant %0d after prev rsp", k), 32'(gcyc[k]), 32'(rcyc[k-1] + 1));
      end
      chk("rr rdata port0", rdat[0], 32'hDEADAAEF);
      chk("rr rdata port1", rdat[1], 32'h11AABB22);
    end
    chk("fixed prio port1 grants", 32'(fp_g1), 32'h0);
    chk("fixed prio port0 grants >= 4", {31'h0, fp_g0 >= 4}, 32'h1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
